ti_share_gen: RTL and testbench



---
 rtl/ti_pkg.sv | 16 +
 rtl/ti_lfsr8.sv | 23 ++
 rtl/ti_share_gen.sv | 109 ++++++++++
 tb/tb_ti_share_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ti_pkg.sv
// ti_pkg: shared constants, state encoding and LFSR helper for the TI masking blocks
package ti_pkg;
    localparam int SHARE_W   = 8;
    localparam int N_SHARES  = 3;
    localparam int N_RAND    = 2;
    localparam int FRAME_LEN = 5;
    localparam logic [31:0] DEF_SEED = 32'hACE1_2468;
    localparam logic [31:0] DEF_POLY = 32'h8020_0003;
    typedef enum logic [1:0] {IDLE, RAND, EMIT, GAP} state_t;
    function automatic logic [31:0] lfsr_adv8(input logic [31:0] s, input logic [31:0] poly);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) v = v[0] ? ((v >> 1) ^ poly) : (v >> 1);
        return v;
    endfunction
endpackage

// File: rtl/ti_lfsr8.sv
// ti_lfsr8: 32-bit Galois LFSR advancing a full byte per enabled cycle, with zero-safe reseed
module ti_lfsr8
    import ti_pkg::*;
#(
    parameter logic [31:0] SEED = DEF_SEED,
    parameter logic [31:0] POLY = DEF_POLY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adv,
    input  logic                 ld,
    input  logic [31:0]          ld_val,
    output logic [SHARE_W-1:0]   s_lo
);
    logic [31:0] s_q, s_d;
    // Reseed wins over advance; an all-zero seed would lock the LFSR, so it maps to SEED
    always_comb s_d = ld ? ((ld_val == '0) ? SEED : ld_val) : adv ? lfsr_adv8(s_q, POLY) : s_q;
    // State register
    always_ff @(posedge clk)
        if (reset) s_q <= SEED;
        else       s_q <= s_d;
    assign s_lo = s_q[SHARE_W-1:0];
endmodule

// File: rtl/ti_share_gen.sv
// ti_share_gen: splits a plaintext byte into three Boolean shares plus two random bytes for the serial TI S-box
module ti_share_gen
    import ti_pkg::*;
#(
    parameter logic [31:0] SEED = DEF_SEED,
    parameter logic [31:0] POLY = DEF_POLY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SHARE_W-1:0]   pt_in,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic                 seed_we,
    input  logic [31:0]          seed_in,
    output logic                 load_out,
    output logic [SHARE_W-1:0]   byte_out,
    output logic                 busy,
    output logic                 frame_done
);
    state_t state_q, state_d;
    logic [1:0] rcnt_q, rcnt_d;
    logic [2:0] ecnt_q, ecnt_d;
    logic [SHARE_W-1:0] pt_q, pt_d, m1_q, m1_d, m2_q, m2_d, r0_q, r0_d, r1_q, r1_d, byte_q, byte_d, rnd;
    logic load_q, load_d;
    ti_lfsr8 #(.SEED(SEED), .POLY(POLY)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .adv    (state_q == RAND),
        .ld     (seed_we && state_q == IDLE),
        .ld_val (seed_in),
        .s_lo   (rnd)
    );
    // Frame sequencing: capture, draw four random bytes, stream five bytes, then one gap cycle
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        ecnt_d  = ecnt_q;
        pt_d    = pt_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        byte_d  = byte_q;
        load_d  = load_q;
        case (state_q)
            IDLE: if (pt_valid) begin
                pt_d    = pt_in;
                rcnt_d  = '0;
                state_d = RAND;
            end
            RAND: begin
                rcnt_d = rcnt_q + 2'd1;
                m1_d   = (rcnt_q == 2'd0) ? rnd : m1_q;
                m2_d   = (rcnt_q == 2'd1) ? rnd : m2_q;
                r0_d   = (rcnt_q == 2'd2) ? rnd : r0_q;
                r1_d   = (rcnt_q == 2'd3) ? rnd : r1_q;
                if (rcnt_q == 2'd3) begin
                    state_d = EMIT;
                    ecnt_d  = '0;
                    load_d  = 1'b1;
                    byte_d  = m1_q;
                end
            end
            EMIT: begin
                ecnt_d = ecnt_q + 3'd1;
                byte_d = (ecnt_q == 3'd0) ? m2_q :
                         (ecnt_q == 3'd1) ? (pt_q ^ m1_q ^ m2_q) :
                         (ecnt_q == 3'd2) ? r0_q :
                         (ecnt_q == 3'd3) ? r1_q : byte_q;
                if (ecnt_q == 3'd4) begin
                    state_d = GAP;
                    load_d  = 1'b0;
                    pt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Registers; reset aborts any frame in progress
    always_ff @(posedge clk)
        if (reset) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            ecnt_q  <= '0;
            pt_q    <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            byte_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            ecnt_q  <= ecnt_d;
            pt_q    <= pt_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            byte_q  <= byte_d;
            load_q  <= load_d;
        end
    assign pt_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == GAP);
    assign load_out   = load_q;
    assign byte_out   = byte_q;
endmodule

// File: tb/tb_ti_share_gen.sv
// tb_ti_share_gen: scoreboard bench for the share generator with a software LFSR reference
module tb_ti_share_gen;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;
    logic clk = 1'b0, reset = 1'b1, pt_valid = 1'b0, seed_we = 1'b0;
    logic [7:0] pt_in = 8'h00;
    logic [31:0] seed_in = 32'h0;
    logic pt_ready, load_out, busy, frame_done;
    logic [7:0] byte_out;
    int n_cmp = 0, n_bad = 0, nbytes = 0;
    logic [7:0] exp_q[$];
    logic [31:0] lf = SEED;
    logic [7:0] last_r1;

    ti_share_gen dut (
        .clk        (clk),
        .reset      (reset),
        .pt_in      (pt_in),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .seed_we    (seed_we),
        .seed_in    (seed_in),
        .load_out   (load_out),
        .byte_out   (byte_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] step8(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            if (v[0]) v = (v >> 1) ^ POLY;
            else      v = v >> 1;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) if (reset) nbytes = 0;

    always @(negedge clk) begin
        if (load_out) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_unexpected: got %0h required none at %0t", byte_out, $time);
            end else chk("byte", byte_out, exp_q.pop_front());
            nbytes++;
        end
        if (frame_done) begin
            chk("frame_len", nbytes, 5);
            nbytes = 0;
        end
    end

    task automatic run_frame(input logic [7:0] pt, input logic sw, input logic [31:0] sv, input int mode);
        logic [7:0] m1, m2, r0, r1;
        int w;
        w = 0;
        while (!pt_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("pt_ready_idle", pt_ready, 1);
        pt_in = pt;
        pt_valid = 1'b1;
        seed_we = sw;
        seed_in = sv;
        @(posedge clk);
        if (sw) lf = (sv == 0) ? SEED : sv;
        m1 = lf[7:0]; lf = step8(lf);
        m2 = lf[7:0]; lf = step8(lf);
        r0 = lf[7:0]; lf = step8(lf);
        r1 = lf[7:0]; lf = step8(lf);
        exp_q.push_back(m1);
        exp_q.push_back(m2);
        exp_q.push_back(pt ^ m1 ^ m2);
        exp_q.push_back(r0);
        exp_q.push_back(r1);
        last_r1 = r1;
        @(negedge clk);
        seed_we = 1'b0;
        chk("pt_ready_drop", pt_ready, 0);
        chk("busy_rand", busy, 1);
        chk("load_rand", load_out, 0);
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (mode == 2 && k == 8) begin
                chk("abort_load", load_out, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ready", pt_ready, 1);
                chk("abort_byte", byte_out, 0);
                chk("abort_done", frame_done, 0);
                reset = 1'b0;
                pt_valid = 1'b0;
                exp_q.delete();
                lf = SEED;
                return;
            end
            if (k <= 4) chk("load_low", load_out, 0);
            else if (k <= 9) chk("load_high", load_out, 1);
            else begin
                chk("gap_done", frame_done, 1);
                chk("gap_load", load_out, 0);
                chk("gap_hold", byte_out, last_r1);
            end
            if (mode == 1 && k == 6) begin
                seed_we = 1'b1;
                seed_in = 32'hDEAD_BEEF;
            end
            if (mode == 1 && k == 7) seed_we = 1'b0;
            if (mode == 2 && k == 7) reset = 1'b1;
        end
        @(negedge clk);
        chk("pt_ready_back", pt_ready, 1);
        pt_valid = 1'b0;
    endtask

    task automatic reseed(input logic [31:0] v);
        @(negedge clk);
        seed_we = 1'b1;
        seed_in = v;
        @(negedge clk);
        seed_we = 1'b0;
        lf = (v == 0) ? SEED : v;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", pt_ready, 1);
        chk("rst_load", load_out, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        reset = 1'b0;
        @(negedge clk);
        run_frame(8'h53, 1'b0, 32'h0, 0);
        run_frame(8'h00, 1'b0, 32'h0, 0);
        run_frame(8'hFF, 1'b0, 32'h0, 0);
        reseed(32'h0);
        run_frame(8'h53, 1'b0, 32'h0, 0);
        reseed(32'h1234_5678);
        run_frame(8'h53, 1'b0, 32'h0, 0);
        run_frame(8'hA5, 1'b1, 32'h0BAD_F00D, 0);
        run_frame(8'h3C, 1'b0, 32'h0, 1);
        run_frame(8'h77, 1'b0, 32'h0, 0);
        run_frame(8'h11, 1'b0, 32'h0, 2);
        run_frame(8'h53, 1'b0, 32'h0, 0);
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
